gcd_stream: RTL and testbench
=============================

// Module: gcd_stream
// PURPOSE
//   Parametrised, handshaked GCD engine; next generation of the fixed 8-bit gcd block.
//   Accepts one operand pair (in_a, in_b) on a valid/ready input and iterates one step per clock.
//   Returns gcd plus an iteration count on a valid/ready output, so it can sit in a request/response pipeline.
//   Handles zero operands, which the 8-bit block did not define.
// PARAMETERS
//   WIDTH  8  operand and result width in bits (>=2)
//   CNT_W  8  width of the iteration counter (out_cycles); saturates at 2**CNT_W-1
// PORTS
//   clk         in   1      clock, all logic on rising edge
//   rst         in   1      synchronous, active-high reset
//   in_valid    in   1      operand pair present
//   in_ready    out  1      engine can accept (high only in IDLE)
//   in_a        in   WIDTH  operand a, unsigned
//   in_b        in   WIDTH  operand b, unsigned
//   out_valid   out  1      result present; held until out_ready
//   out_ready   in   1      consumer accepts result
//   out_gcd     out  WIDTH  gcd(a,b); stable while out_valid
//   out_cycles  out  CNT_W  RUN cycles used for this result, saturating
// BEHAVIOUR
//   States: IDLE -> RUN -> DONE -> IDLE. Reset: state=IDLE, in_ready=1, out_valid=0, out_gcd=0, out_cycles=0.
//   IDLE: in_ready=1. in_valid&in_ready latches a,b into working regs, clears counter and shift count k, goes to RUN.
//   RUN: in_ready=0, out_valid=0. Each cycle the counter increments (saturating), then exactly one of these applies:
//     a==0 -> result=b, DONE.  b==0 -> result=a, DONE.  a==b -> result=a, DONE.
//     otherwise larger := larger - smaller (default algorithm), stay in RUN.
//   The terminating cycle is counted. gcd(0,0)=0 in 1 cycle.
//   DONE: out_valid=1, and out_gcd/out_cycles are registered and stable. out_ready -> IDLE on the next edge.
//     in_ready rises the cycle after the output handshake; there is no same-cycle bypass.
//   Latency: accept edge + N RUN cycles; out_valid asserts the cycle after the terminating RUN cycle.
//   Arithmetic: unsigned WIDTH-bit only. Subtraction never underflows (larger minus smaller). No overflow is possible.
//   Counter: out_cycles = min(N, 2**CNT_W-1). Saturation is silent.
//   Input handshake while not IDLE: ignored, because in_ready=0. The producer must hold its data.
//   out_ready while not DONE: ignored.
//   rst mid-RUN or in DONE: the operation is discarded and no result is emitted. State returns to reset values next edge.
// CONFIGURATION
//   GCD_BINARY_EN defined: Stein's binary algorithm replaces the subtract step in RUN when a,b are both non-zero and unequal:
//     both even -> a>>=1, b>>=1, k++
//     only a even -> a>>=1
//     only b even -> b>>=1
//     both odd -> larger := larger - smaller
//   Termination tests are unchanged. The result is (terminal value) << k.
//   k register width = $clog2(WIDTH)+1.
//   Without the macro: plain subtractive Euclid as above; no k register; no shifter.
// STRUCTURE
//   gcd_pkg: state enum (IDLE, RUN, DONE) and the counter-saturate helper function.
//   Sub-module gcd_step: combinational single iteration, (a,b,k) -> (a',b',k',done,result).
//     It holds the GCD_BINARY_EN split.
//   gcd_stream itself: FSM, handshakes, working regs, counter.
// TESTING
//   1. in_a=48,in_b=18 -> out_gcd=6. Default build: out_cycles=5. GCD_BINARY_EN build: out_cycles=7.
//   2. (0,0) -> out_gcd=0, out_cycles=1. (0,35) -> 35, 1 cycle. (35,0) -> 35, 1 cycle.
//   3. WIDTH=8, (255,1), default build -> out_gcd=1, out_cycles=255.
//      Same with CNT_W=4 -> out_cycles=15 (saturated).
//   4. out_ready held low 10 cycles after (21,14) -> out_valid and out_gcd=7 stable throughout.
//      in_ready stays 0; in_ready=1 one cycle after the handshake.
//   5. rst pulsed 1 cycle mid-RUN of (255,1) -> out_valid never asserts.
//      in_ready=1 after reset; the next pair (12,8) yields 4.
//   6. WIDTH=16, back-to-back pairs with in_valid constant high: (65535,4369)->4369, (1000,600)->200, (17,13)->1.
//      Results are returned in order and none are dropped.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the gcd_stream engine.
// Optional feature macro: GCD_BINARY_EN (Stein's binary step in gcd_step).
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Increment an up-to-32-bit counter of width w, sticking at its all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int w);
        logic [31:0] max;
        max = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (cnt >= max) ? max : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: termination test plus one reduction step.
// With GCD_BINARY_EN the reduction is Stein's binary step and a power-of-two
// shift count k is carried; otherwise it is plain subtractive Euclid.
module gcd_step #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef GCD_BINARY_EN
    input  logic [KW-1:0]    k,
    output logic [KW-1:0]    k_nxt,
`endif
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] b_nxt,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] term;

    // Terminal value: a zero operand yields the other one, equal operands yield either.
    always_comb begin
        done = (a == '0) || (b == '0) || (a == b);
        term = (a == '0) ? b : a;
    end

`ifdef GCD_BINARY_EN
    // Binary reduction: strip common twos into k, strip lone twos, else subtract.
    always_comb begin
        a_nxt  = a;
        b_nxt  = b;
        k_nxt  = k;
        result = term << k;
        if (!a[0] && !b[0]) begin
            a_nxt = a >> 1;
            b_nxt = b >> 1;
            k_nxt = k + 1'b1;
        end else if (!a[0]) begin
            a_nxt = a >> 1;
        end else if (!b[0]) begin
            b_nxt = b >> 1;
        end else if (a > b) begin
            a_nxt = a - b;
        end else begin
            b_nxt = b - a;
        end
    end
`else
    // Subtractive reduction: larger minus smaller, never underflows.
    always_comb begin
        result = term;
        a_nxt  = (a > b) ? a - b : a;
        b_nxt  = (b > a) ? b - a : b;
    end
`endif

endmodule

// File: rtl/gcd_stream.sv
// Handshaked GCD engine: accepts an operand pair, iterates one step per clock,
// returns gcd and a saturating count of RUN cycles.
// Optional feature macro: GCD_BINARY_EN (binary algorithm, adds shift count k).
module gcd_stream
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8   // counter helper works on up to 32 bits
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CNT_W-1:0] out_cycles
);

    localparam int KW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] a_nxt, b_nxt, result;
    logic             done;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
`ifdef GCD_BINARY_EN
    logic [KW-1:0]    k_q, k_nxt;
`endif

    gcd_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .a      (a_q),
        .b      (b_q),
`ifdef GCD_BINARY_EN
        .k      (k_q),
        .k_nxt  (k_nxt),
`endif
        .a_nxt  (a_nxt),
        .b_nxt  (b_nxt),
        .done   (done),
        .result (result)
    );

    // Count includes the current RUN cycle, so the terminating cycle is counted.
    always_comb begin
        cnt_nxt = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_gcd    <= '0;
            out_cycles <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
`ifdef GCD_BINARY_EN
            k_q        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        cnt_q    <= '0;
`ifdef GCD_BINARY_EN
                        k_q      <= '0;
`endif
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_nxt;
                    if (done) begin
                        out_gcd    <= result;
                        out_cycles <= cnt_nxt;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        a_q <= a_nxt;
                        b_q <= b_nxt;
`ifdef GCD_BINARY_EN
                        k_q <= k_nxt;
`endif
                    end
                end
                DONE: begin
                    // in_ready comes back only after the output handshake edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_stream.sv
// Directed self-checking bench for gcd_stream: three instances
// (8-bit/8-bit count, 8-bit/4-bit count sharing stimulus, 16-bit).
module tb_gcd_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic        in_ready, out_valid;
    logic [7:0]  out_gcd;
    logic [7:0]  out_cycles;
    logic        in_ready4, out_valid4;
    logic [7:0]  out_gcd4;
    logic [3:0]  out_cycles4;
    logic        in_valid16, out_ready16, in_ready16, out_valid16;
    logic [15:0] in_a16, in_b16, out_gcd16;
    logic [7:0]  out_cycles16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gcd_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_gcd(out_gcd), .out_cycles(out_cycles)
    );

    gcd_stream #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid4), .out_ready(out_ready),
        .out_gcd(out_gcd4), .out_cycles(out_cycles4)
    );

    gcd_stream #(.WIDTH(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .out_gcd(out_gcd16), .out_cycles(out_cycles16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a pair, accept it, wait (bounded) for out_valid; result stays pending.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         output int lat, output bit to);
        int w;
        in_a = a; in_b = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin step(); w++; end
        step();
        in_valid = 1'b0;
        lat = 0; to = 1'b0;
        while (!out_valid) begin
            step(); lat++;
            if (lat > 2000) begin to = 1'b1; break; end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    int          lat;
    bit          to;
    bit          seen;
    logic [15:0] pa [3];
    logic [15:0] pb [3];
    logic [15:0] pe [3];
    int          sent, got;
    bit          acc, res;
    logic [15:0] g;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; in_a16 = '0; in_b16 = '0;
        step(); step();
        rst = 1'b0;

        // reset state
        check("rst_in_ready",   32'(in_ready),   1);
        check("rst_out_valid",  32'(out_valid),  0);
        check("rst_out_gcd",    32'(out_gcd),    0);
        check("rst_out_cycles", 32'(out_cycles), 0);

        // 48,18
        issue(8'd48, 8'd18, lat, to);
        check("t1_timeout", 32'(to), 0);
        check("t1_gcd", 32'(out_gcd), 6);
`ifdef GCD_BINARY_EN
        check("t1_cycles", 32'(out_cycles), 7);
        check("t1_latency", 32'(lat), 7);
`else
        check("t1_cycles", 32'(out_cycles), 5);
        check("t1_latency", 32'(lat), 5);
`endif
        check("t1_in_ready_busy", 32'(in_ready), 0);
        consume();

        // zero operands
        issue(8'd0, 8'd0, lat, to);
        check("t2a_gcd", 32'(out_gcd), 0);
        check("t2a_cycles", 32'(out_cycles), 1);
        consume();
        issue(8'd0, 8'd35, lat, to);
        check("t2b_gcd", 32'(out_gcd), 35);
        check("t2b_cycles", 32'(out_cycles), 1);
        consume();
        issue(8'd35, 8'd0, lat, to);
        check("t2c_gcd", 32'(out_gcd), 35);
        check("t2c_cycles", 32'(out_cycles), 1);
        consume();

        // long run and counter saturation
        issue(8'd255, 8'd1, lat, to);
        check("t3_timeout", 32'(to), 0);
        check("t3_gcd", 32'(out_gcd), 1);
        check("t3_gcd_c4", 32'(out_gcd4), 1);
        check("t3_valid_c4", 32'(out_valid4), 1);
`ifdef GCD_BINARY_EN
        check("t3_cycles", 32'(out_cycles), 15);
`else
        check("t3_cycles", 32'(out_cycles), 255);
`endif
        check("t3_cycles_c4", 32'(out_cycles4), 15);
        consume();

        // back-pressure: result held stable
        issue(8'd21, 8'd14, lat, to);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", 32'(out_valid), 1);
            check("t4_hold_gcd", 32'(out_gcd), 7);
            check("t4_hold_in_ready", 32'(in_ready), 0);
            step();
        end
        consume();
        check("t4_in_ready_after", 32'(in_ready), 1);
        check("t4_valid_after", 32'(out_valid), 0);

        // reset mid-RUN discards the operation
        in_a = 8'd255; in_b = 8'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_in_ready_rst", 32'(in_ready), 1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("t5_no_result", 32'(seen), 0);
        issue(8'd12, 8'd8, lat, to);
        check("t5_next_gcd", 32'(out_gcd), 4);
        consume();

        // 16-bit back-to-back stream, in_valid and out_ready held high
        pa[0] = 16'd65535; pb[0] = 16'd4369; pe[0] = 16'd4369;
        pa[1] = 16'd1000;  pb[1] = 16'd600;  pe[1] = 16'd200;
        pa[2] = 16'd17;    pb[2] = 16'd13;   pe[2] = 16'd1;
        sent = 0; got = 0;
        in_a16 = pa[0]; in_b16 = pb[0]; in_valid16 = 1'b1; out_ready16 = 1'b1;
        for (int c = 0; c < 2000 && got < 3; c++) begin
            acc = in_valid16 && in_ready16;
            res = out_valid16;
            g   = out_gcd16;
            step();
            if (res) begin
                check($sformatf("t6_gcd%0d", got), 32'(g), 32'(pe[got]));
                got++;
            end
            if (acc) begin
                sent++;
                if (sent < 3) begin
                    in_a16 = pa[sent]; in_b16 = pb[sent];
                end else begin
                    in_valid16 = 1'b0;
                end
            end
        end
        check("t6_count", 32'(got), 3);
        out_ready16 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
